// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM slice.
// Holds the FSM state encodings and the default timing for 1 us ticks
// derived from a 50 MHz system clock: 20 ms period, 1.0-2.0 ms pulses.
package servo_pkg;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Default timing in ticks
  localparam int unsigned DEF_PERIOD_TICKS     = 20000;
  localparam int unsigned DEF_MIN_PULSE        = 1000;
  localparam int unsigned DEF_MAX_PULSE        = 2000;
  localparam int unsigned DEF_NEUTRAL_PULSE    = 1500;
  localparam int unsigned DEF_WIDTH            = 16;
  localparam int unsigned DEF_FAILSAFE_PERIODS = 50;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the clock generator's divided timebase.
// Ports:
//   clk_in      - system clock
//   rst_n       - asynchronous active-low reset
//   tick_in     - divided timebase, clk_in domain
//   tick_rise_c - combinational one-cycle strobe on each tick_in rising edge
module tick_edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick_in,
  output logic tick_rise_c
);

  logic tick_d;

  // Reset high so a tick_in already high at reset release is not a tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tick_d <= 1'b1;
    else        tick_d <= tick_in;
  end

  assign tick_rise_c = tick_in & ~tick_d;

endmodule

// File: rtl/servo_pwm.sv
// RC-servo pulse generator: one PERIOD_TICKS-long period per cycle, high
// for active_width ticks. New widths arrive over valid/ready, are clamped
// to [MIN_PULSE, MAX_PULSE] and only take effect at a period boundary.
// Ports:
//   clk_in, rst_n        - system clock, asynchronous active-low reset
//   tick_in              - divided timebase; each rising edge is one tick
//   enable               - high runs the generator, low forces IDLE
//   cmd_width/cmd_valid  - requested high time in ticks, with valid
//   cmd_ready            - one-deep pending slot is free
//   pwm_out              - registered servo pulse
//   period_start         - one-cycle strobe at each period boundary
//   failsafe             - neutral width forced by command timeout
// Optional feature: define SERVO_PWM_FAILSAFE_EN to enable the command
// timeout; otherwise failsafe is tied low and the last width holds.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS     = DEF_PERIOD_TICKS,
  parameter int unsigned MIN_PULSE        = DEF_MIN_PULSE,
  parameter int unsigned MAX_PULSE        = DEF_MAX_PULSE,
  parameter int unsigned NEUTRAL_PULSE    = DEF_NEUTRAL_PULSE,
  parameter int unsigned WIDTH            = DEF_WIDTH,
  parameter int unsigned FAILSAFE_PERIODS = DEF_FAILSAFE_PERIODS
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] cmd_width,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             failsafe
);

  localparam logic [WIDTH-1:0] LAST_TICK = WIDTH'(PERIOD_TICKS - 1);
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_PULSE);
  localparam logic [WIDTH-1:0] NEUTRAL_W = WIDTH'(NEUTRAL_PULSE);

  // Elaboration-time parameter sanity
  if ((PERIOD_TICKS < 2) || ((PERIOD_TICKS - 1) >= (2 ** WIDTH))) begin : g_bad_period
    $error("servo_pwm: PERIOD_TICKS does not fit the counter");
  end
  if ((MIN_PULSE > MAX_PULSE) || (MAX_PULSE >= PERIOD_TICKS) ||
      (NEUTRAL_PULSE < MIN_PULSE) || (NEUTRAL_PULSE > MAX_PULSE) ||
      (FAILSAFE_PERIODS == 0)) begin : g_bad_pulse
    $error("servo_pwm: inconsistent pulse or failsafe parameters");
  end

  logic             tick_rise;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] cmd_clamped_c;
  logic             accept, boundary, pwm_d;

`ifdef SERVO_PWM_FAILSAFE_EN
  localparam int unsigned     FS_W     = $clog2(FAILSAFE_PERIODS + 1);
  localparam logic [FS_W-1:0] FS_LIMIT = FS_W'(FAILSAFE_PERIODS);
  logic [FS_W-1:0] fs_cnt_q, fs_cnt_d;
  logic            failsafe_d;
`endif

  tick_edge_detect u_tick (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .tick_in     (tick_in),
    .tick_rise_c (tick_rise)
  );

  assign cmd_clamped_c = (cmd_width < MIN_W) ? MIN_W :
                         (cmd_width > MAX_W) ? MAX_W : cmd_width;

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, counter, width and command-slot logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    boundary   = 1'b0;
    accept     = cmd_valid & cmd_ready;
`ifdef SERVO_PWM_FAILSAFE_EN
    fs_cnt_d   = fs_cnt_q;
    failsafe_d = failsafe;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable && tick_rise) begin
          state_d  = ST_RUN;
          boundary = 1'b1;
        end
      end
      default: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick_rise) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
    endcase

    // Boundary consumes only what was pending before this cycle.
    if (boundary) begin
      if (pend_vld_q) begin
        active_d   = pend_q;
        pend_vld_d = 1'b0;
      end
`ifdef SERVO_PWM_FAILSAFE_EN
      else if (fs_cnt_q >= FS_LIMIT) begin
        active_d   = NEUTRAL_W;
        failsafe_d = 1'b1;
      end
      // Saturate so failsafe keeps re-asserting the neutral width.
      if (fs_cnt_q != FS_LIMIT) fs_cnt_d = fs_cnt_q + FS_W'(1);
`endif
    end

    if (accept) begin
      pend_d     = cmd_clamped_c;
      pend_vld_d = 1'b1;
`ifdef SERVO_PWM_FAILSAFE_EN
      fs_cnt_d   = '0;
      failsafe_d = 1'b0;
`endif
    end

    pwm_d = (state_d == ST_RUN) && (cnt_d < active_d);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      active_q     <= NEUTRAL_W;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      cmd_ready    <= 1'b1;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      cmd_ready    <= ~pend_vld_d;
      pwm_out      <= pwm_d;
      period_start <= boundary;
    end
  end

`ifdef SERVO_PWM_FAILSAFE_EN
  // Command timeout tracking
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      fs_cnt_q <= '0;
      failsafe <= 1'b0;
    end else begin
      fs_cnt_q <= fs_cnt_d;
      failsafe <= failsafe_d;
    end
  end
`else
  assign failsafe = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm.sv
// Directed bench for servo_pwm with scaled-down timing (period 200 ticks,
// pulses 10..20, neutral 15, timeout 5 periods). tick_in toggles every clock
// so one tick is two clk_in cycles; high times are checked in clocks (2*w).
module tb_servo_pwm;

  localparam int unsigned P    = 200;
  localparam int unsigned LIM  = 3 * 2 * P;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] cmd_width = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, pwm_out, period_start, failsafe;

  logic        tick_gen = 1'b0;
  logic        tick_force = 1'b1;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int hi_cnt = 0;
  int last_hi = 0;
  int ps_cnt = 0;
  int last_ps = 0;
  int last_period = 0;

  servo_pwm #(
    .PERIOD_TICKS     (P),
    .MIN_PULSE        (10),
    .MAX_PULSE        (20),
    .NEUTRAL_PULSE    (15),
    .WIDTH            (16),
    .FAILSAFE_PERIODS (5)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .tick_in      (tick_in),
    .enable       (enable),
    .cmd_width    (cmd_width),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .failsafe     (failsafe)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) tick_in <= tick_gen ? ~tick_in : tick_force;

  // Pulse and period measurement
  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (pwm_out) hi_cnt <= hi_cnt + 1;
    else if (hi_cnt != 0) begin
      last_hi <= hi_cnt;
      hi_cnt  <= 0;
    end
    if (period_start) begin
      ps_cnt      <= ps_cnt + 1;
      last_period <= cyc - last_ps;
      last_ps     <= cyc;
    end
  end

  task automatic issue_cmd(input logic [15:0] w);
    @(posedge clk_in); #1;
    cmd_width = w;
    cmd_valid = 1'b1;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ps();
    bit ok = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk_in);
      if (period_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_ps timeout got no period_start want one within %0d cycles", LIM);
    end
  endtask

  task automatic wait_rise();
    bit ok = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk_in);
      if (pwm_out) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_rise timeout got pwm_out low want high within %0d cycles", LIM);
    end
  endtask

  // Waits for the end of the current (or next) pulse; last_hi is then valid.
  task automatic wait_fall();
    bit ok = 1'b0;
    bit seen = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk_in);
      if (pwm_out) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_fall timeout got no falling edge want one within %0d cycles", LIM);
    end
    @(posedge clk_in);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; tick_gen = 1'b0; tick_force = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got %b want 0", period_start); end
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL reset_failsafe got %b want 0", failsafe); end
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    enable = 1'b1;
    // tick_in held high across reset release: no tick may be counted
    repeat (20) @(posedge clk_in);
    checks++; if (ps_cnt !== 0) begin errors++; $display("FAIL held_tick_ps got %0d want 0", ps_cnt); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL held_tick_pwm got %b want 0", pwm_out); end
    #1 tick_gen = 1'b1;
    wait_ps();
    wait_fall();
    checks++; if (last_hi !== 30) begin errors++; $display("FAIL first_pulse got %0d want 30", last_hi); end
    wait_ps();
    @(posedge clk_in);
    checks++; if (last_period !== 2 * P) begin errors++; $display("FAIL first_period got %0d want %0d", last_period, 2 * P); end
  endtask

  task automatic test_cmd_mid();
    wait_rise();
    repeat (4) @(posedge clk_in);
    issue_cmd(16'd12);
    wait_fall();
    checks++; if (last_hi !== 30) begin errors++; $display("FAIL mid_current got %0d want 30", last_hi); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low got %b want 0", cmd_ready); end
    wait_ps();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_high got %b want 1", cmd_ready); end
    wait_fall();
    checks++; if (last_hi !== 24) begin errors++; $display("FAIL mid_next got %0d want 24", last_hi); end
  endtask

  task automatic test_clamp();
    issue_cmd(16'd5);
    wait_ps();
    wait_fall();
    checks++; if (last_hi !== 20) begin errors++; $display("FAIL clamp_low got %0d want 20", last_hi); end
    issue_cmd(16'd25);
    wait_ps();
    wait_fall();
    checks++; if (last_hi !== 40) begin errors++; $display("FAIL clamp_high got %0d want 40", last_hi); end
  endtask

  task automatic test_back_to_back();
    int n0;
    wait_ps();
    // Next boundary edge is exactly 2*P clocks after the one just strobed.
    repeat (2 * P - 1) @(posedge clk_in);
    #1;
    n0 = ps_cnt;
    cmd_width = 16'd12;
    cmd_valid = 1'b1;
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
    @(negedge clk_in);
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL b2b_ps got %b want 1", period_start); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b want 0", cmd_ready); end
    wait_fall();
    checks++; if (last_hi !== 40) begin errors++; $display("FAIL b2b_old_width got %0d want 40", last_hi); end
    checks++; if (ps_cnt !== n0 + 1) begin errors++; $display("FAIL b2b_ps_count got %0d want %0d", ps_cnt, n0 + 1); end
    wait_ps();
    wait_fall();
    checks++; if (last_hi !== 24) begin errors++; $display("FAIL b2b_new_width got %0d want 24", last_hi); end
  endtask

  task automatic test_enable_drop();
    int n;
    wait_ps();
    repeat (14) @(posedge clk_in);
    #1 enable = 1'b0;
    @(negedge clk_in);
    checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL drop_before got %b want 1", pwm_out); end
    @(negedge clk_in);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL drop_after got %b want 0", pwm_out); end
    n = ps_cnt;
    repeat (20) @(posedge clk_in);
    checks++; if (ps_cnt !== n) begin errors++; $display("FAIL idle_ps got %0d want %0d", ps_cnt, n); end
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL idle_pwm got %b want 0", pwm_out); end
    issue_cmd(16'd18);
    @(negedge clk_in);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL idle_pending got %b want 0", cmd_ready); end
    @(posedge clk_in); #1;
    enable = 1'b1;
    wait_ps();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reenable_ready got %b want 1", cmd_ready); end
    wait_fall();
    checks++; if (last_hi !== 36) begin errors++; $display("FAIL reenable_pulse got %0d want 36", last_hi); end
    wait_ps();
    @(posedge clk_in);
    checks++; if (last_period !== 2 * P) begin errors++; $display("FAIL reenable_period got %0d want %0d", last_period, 2 * P); end
  endtask

`ifdef SERVO_PWM_FAILSAFE_EN
  task automatic test_failsafe();
    issue_cmd(16'd18);
    for (int k = 1; k <= 5; k++) begin
      wait_ps();
      checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL fs_early_flag period %0d got %b want 0", k, failsafe); end
      wait_fall();
      checks++; if (last_hi !== 36) begin errors++; $display("FAIL fs_hold period %0d got %0d want 36", k, last_hi); end
    end
    wait_ps();
    checks++; if (failsafe !== 1'b1) begin errors++; $display("FAIL fs_flag got %b want 1", failsafe); end
    wait_fall();
    checks++; if (last_hi !== 30) begin errors++; $display("FAIL fs_neutral got %0d want 30", last_hi); end
    issue_cmd(16'd11);
    @(negedge clk_in);
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL fs_clear got %b want 0", failsafe); end
    wait_ps();
    wait_fall();
    checks++; if (last_hi !== 22) begin errors++; $display("FAIL fs_recover got %0d want 22", last_hi); end
  endtask
`else
  task automatic test_failsafe();
    @(negedge clk_in);
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL fs_tied got %b want 0", failsafe); end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_mid();
    test_clamp();
    test_back_to_back();
    test_enable_drop();
    test_failsafe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm.md
# servo_pwm

RC-servo pulse generator that consumes the divided timebase produced by the codebase's clock generator. It counts rising edges of that timebase as ticks (1 µs at default 1 MHz) and emits a 20 ms-period pulse whose high time tracks a commanded width. Commands arrive over a valid/ready handshake and are applied only at period boundaries, so pulses are never truncated or stretched. It sits between the clock generator and the servo output pins, one instance per servo channel.

## Interface
- PERIOD_TICKS, 20000, ticks per PWM period
- MIN_PULSE, 1000, minimum high time in ticks; commands below are clamped up
- MAX_PULSE, 2000, maximum high time in ticks; commands above are clamped down
- NEUTRAL_PULSE, 1500, high time applied after reset and on failsafe
- WIDTH, 16, width of the counter and command bus; must hold PERIOD_TICKS-1
- FAILSAFE_PERIODS, 50, consecutive periods without a command before failsafe triggers
- clk_in  input  1  system clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- tick_in  input  1  divided clock from the clock generator, same clk_in domain; rising edge = one tick
- enable  input  1  high = generate pulses; low = output held low
- cmd_width  input  WIDTH  requested high time in ticks
- cmd_valid  input  1  cmd_width valid this cycle
- cmd_ready  output  1  block can accept a command
- pwm_out  output  1  servo pulse, registered
- period_start  output  1  one-cycle strobe at the start of each period
- failsafe  output  1  high while the neutral width is forced by timeout

## Operation
- Reset values: pwm_out=0, cmd_ready=1, period_start=0, failsafe=0, active_width=NEUTRAL_PULSE, pending empty, tick counter=0, state IDLE, tick_d=1. Reset tick_d to 1 so a high tick_in at reset release does not produce a spurious tick.
- Tick detection: tick_rise = tick_in & ~tick_d, with tick_d registered each clk_in. Only tick_rise advances timing.
- Command path: the pending register is one deep. cmd_ready = ~pending_valid. A command is accepted when cmd_valid & cmd_ready. On accept, the value is clamped to [MIN_PULSE, MAX_PULSE] and stored in pending.
- States:
  - IDLE: pwm_out=0, counter=0. Go to RUN on the first tick_rise with enable=1.
  - RUN: the counter increments on each tick_rise and wraps from PERIOD_TICKS-1 to 0.
  - Any state: enable=0 returns to IDLE on the next clk_in. No partial pulse completes. pending is retained.
- Boundary: boundary = the tick_rise that sets counter to 0, including IDLE→RUN entry.
  - At a boundary, active_width loads pending if pending is valid, and pending clears.
  - period_start pulses for that one cycle.
- Output: pwm_out = RUN & (counter < active_width), registered.
- Simultaneous accept and boundary: the boundary consumes the old pending contents only. A command accepted in the same cycle goes to pending and applies at the next boundary.

## Timing
- pwm_out rises 1 clk_in after the boundary tick_rise and falls 1 clk_in after the tick_rise where counter reaches active_width.
- High time is exactly active_width ticks. Period is exactly PERIOD_TICKS ticks.
- Command-to-effect latency: up to 1 period plus 1 clk_in.
- cmd_ready deasserts the cycle after accept and reasserts the cycle after the boundary that drains pending.

## Configuration
- SERVO_PWM_FAILSAFE_EN defined:
  - A period counter increments at each boundary and resets on every command accept.
  - When it reaches FAILSAFE_PERIODS, the next boundary loads NEUTRAL_PULSE instead of active_width and sets failsafe=1.
  - failsafe clears on the next accept. Pending takes precedence at a boundary.
- SERVO_PWM_FAILSAFE_EN undefined: no timeout logic; failsafe tied 0; the last width holds indefinitely.

## Structure
- Package servo_pkg: state enum (IDLE, RUN) and default constants for 50 MHz/1 MHz operation (period, min, max, neutral).
- Sub-module tick_edge_detect: tick_d register plus rising-edge strobe. This is reusable by other consumers of the clock generator.

## Test plan
- Reset with tick_in held high, then enable=1 → no tick counted until tick_in falls and rises; first pulse is 1500 ticks high within a 20000-tick period.
- Command 1200 mid-period → current pulse unchanged; next period high exactly 1200 ticks; cmd_ready low until that boundary.
- Commands 500 and 2500 → applied widths are 1000 and 2000 respectively.
- Command accepted in the same cycle as a boundary with pending empty → width applies one period later; period_start seen once.
- enable dropped at tick 700 of the high phase → pwm_out low on the next clk_in; re-enable gives a full pulse with the latest width.
- With SERVO_PWM_FAILSAFE_EN: command 1800, then silence for 50 periods → period 51 is 1500 ticks and failsafe=1; a new command of 1100 clears failsafe and the next period is 1100 ticks.
